// File: rtl/cmd_rx_pkg.sv
// cmd_rx_pkg: shared definitions for the FE-I4 serial command receiver.
// Holds the receiver state encoding, the decoded command type encoding,
// the header / field codes of the protocol and the length of each field.
package cmd_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FIELD2 = 3'd2,
    ST_FIELD3 = 3'd3,
    ST_CHIPID = 3'd4,
    ST_ADDR   = 3'd5,
    ST_DATA   = 3'd6,
    ST_FEDATA = 3'd7
  } rx_state_e;

  typedef enum logic [3:0] {
    CMD_NONE         = 4'd0,
    CMD_LV1          = 4'd1,
    CMD_BCR          = 4'd2,
    CMD_ECR          = 4'd3,
    CMD_CAL          = 4'd4,
    CMD_RD_REG       = 4'd5,
    CMD_WR_REG       = 4'd6,
    CMD_WR_FE        = 4'd7,
    CMD_GLOBAL_RESET = 4'd8,
    CMD_GLOBAL_PULSE = 4'd9,
    CMD_RUN_MODE     = 4'd10
  } cmd_type_e;

  // Header codes (5 bits, first bit always 1)
  localparam logic [4:0] HDR_LV1  = 5'b11101;
  localparam logic [4:0] HDR_FAST = 5'b10110;

  // Second field of a fast/slow command
  localparam logic [3:0] F2_BCR  = 4'b0001;
  localparam logic [3:0] F2_ECR  = 4'b0010;
  localparam logic [3:0] F2_CAL  = 4'b0100;
  localparam logic [3:0] F2_SLOW = 4'b1000;

  // Third field selecting the slow command
  localparam logic [3:0] F3_RD_REG       = 4'b0001;
  localparam logic [3:0] F3_WR_REG       = 4'b0010;
  localparam logic [3:0] F3_WR_FE        = 4'b0100;
  localparam logic [3:0] F3_GLOBAL_RESET = 4'b1000;
  localparam logic [3:0] F3_GLOBAL_PULSE = 4'b1001;
  localparam logic [3:0] F3_RUN_MODE     = 4'b1010;

  // Field lengths in bits, in bit-counter width
  localparam logic [9:0] LEN_HEADER = 10'd5;
  localparam logic [9:0] LEN_FIELD2 = 10'd4;
  localparam logic [9:0] LEN_FIELD3 = 10'd4;
  localparam logic [9:0] LEN_CHIPID = 10'd4;
  localparam logic [9:0] LEN_ADDR   = 10'd6;
  localparam logic [9:0] LEN_DATA   = 10'd16;

endpackage

// File: rtl/cmd_rx.sv
// cmd_rx: serial FE-I4 command receiver and decoder.
// Samples one command bit per BUS_CLK cycle (MSB first), frames trigger,
// fast and slow commands and presents each as a registered one-cycle record.
// Ports:
//   BUS_CLK        clock, one command bit per cycle
//   BUS_RST        synchronous active-high reset
//   CMD_DATA       serial command bit, idle line is 0
//   CMD_VALID      one-cycle pulse, record fields valid
//   CMD_TYPE       decoded command type (cmd_type_e)
//   CMD_CHIPID     chip ID of slow commands, 0 otherwise
//   CMD_ADDR       address / pulse width / run-mode field, 0 if absent
//   CMD_VALUE      WR_REG data, 0 otherwise
//   CMD_ERROR      one-cycle pulse on an unrecognised header or field
//   TRIGGER_COUNT  number of LV1 received, wraps
//   RX_BUSY        high while a command is being framed
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int FE_DATA_BITS  = 672,
  parameter int TRG_CNT_WIDTH = 16
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic                     CMD_DATA,
  output logic                     CMD_VALID,
  output logic [3:0]               CMD_TYPE,
  output logic [3:0]               CMD_CHIPID,
  output logic [5:0]               CMD_ADDR,
  output logic [15:0]              CMD_VALUE,
  output logic                     CMD_ERROR,
  output logic [TRG_CNT_WIDTH-1:0] TRIGGER_COUNT,
  output logic                     RX_BUSY
);

  localparam logic [9:0]               LEN_FEDATA = 10'(FE_DATA_BITS);
  localparam logic [TRG_CNT_WIDTH-1:0] TRG_ONE    = TRG_CNT_WIDTH'(1);

  rx_state_e                state_r, state_s;
  logic [9:0]               cnt_r, cnt_s;
  logic [14:0]              sh_r, sh_s;
  cmd_type_e                kind_r, kind_s;
  logic [3:0]               chipid_r, chipid_s;
  logic [5:0]               addr_r, addr_s;

  logic                     valid_r, error_r, busy_r;
  cmd_type_e                type_r;
  logic [3:0]               ochip_r;
  logic [5:0]               oaddr_r;
  logic [15:0]              ovalue_r;
  logic [TRG_CNT_WIDTH-1:0] trg_r, trg_s;

  logic                     emit_s, err_s;
  cmd_type_e                etype_s;
  logic [3:0]               echip_s;
  logic [5:0]               eaddr_s;
  logic [15:0]              evalue_s;
  logic [15:0]              shifted_s;
  logic [9:0]               cnt_inc_s;
  logic [9:0]               len_s;

  // Field length of the field currently being received
  always_comb begin
    len_s = LEN_HEADER;
    case (state_r)
      ST_HEADER: len_s = LEN_HEADER;
      ST_FIELD2: len_s = LEN_FIELD2;
      ST_FIELD3: len_s = LEN_FIELD3;
      ST_CHIPID: len_s = LEN_CHIPID;
      ST_ADDR:   len_s = LEN_ADDR;
      ST_DATA:   len_s = LEN_DATA;
      ST_FEDATA: len_s = LEN_FEDATA;
      default:   len_s = LEN_HEADER;
    endcase
  end

  // Next-state, field capture and emission decode
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    sh_s      = sh_r;
    kind_s    = kind_r;
    chipid_s  = chipid_r;
    addr_s    = addr_r;
    emit_s    = 1'b0;
    err_s     = 1'b0;
    etype_s   = kind_r;
    echip_s   = chipid_r;
    eaddr_s   = addr_r;
    evalue_s  = 16'h0000;
    trg_s     = trg_r;
    shifted_s = {sh_r, CMD_DATA};
    cnt_inc_s = cnt_r + 10'd1;

    if (state_r == ST_IDLE) begin
      if (CMD_DATA) begin
        // Start bit is the first header bit, so the header count starts at 1
        state_s  = ST_HEADER;
        cnt_s    = 10'd1;
        sh_s     = 15'h0001;
        kind_s   = CMD_NONE;
        chipid_s = 4'h0;
        addr_s   = 6'h00;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (cnt_inc_s == len_s) begin
      // Last bit of the current field: shifter restarts for the next field
      cnt_s = 10'd0;
      sh_s  = 15'h0000;
      case (state_r)
        ST_HEADER: begin
          if (shifted_s[4:0] == HDR_LV1) begin
            emit_s  = 1'b1;
            etype_s = CMD_LV1;
            trg_s   = trg_r + TRG_ONE;
            state_s = ST_IDLE;
          end else if (shifted_s[4:0] == HDR_FAST) begin
            state_s = ST_FIELD2;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end
        ST_FIELD2: begin
          state_s = ST_IDLE;
          case (shifted_s[3:0])
            F2_BCR:  begin emit_s = 1'b1; etype_s = CMD_BCR; end
            F2_ECR:  begin emit_s = 1'b1; etype_s = CMD_ECR; end
            F2_CAL:  begin emit_s = 1'b1; etype_s = CMD_CAL; end
            F2_SLOW: state_s = ST_FIELD3;
            default: err_s = 1'b1;
          endcase
        end
        ST_FIELD3: begin
          state_s = ST_CHIPID;
          case (shifted_s[3:0])
            F3_RD_REG:       kind_s = CMD_RD_REG;
            F3_WR_REG:       kind_s = CMD_WR_REG;
            F3_WR_FE:        kind_s = CMD_WR_FE;
            F3_GLOBAL_RESET: kind_s = CMD_GLOBAL_RESET;
            F3_GLOBAL_PULSE: kind_s = CMD_GLOBAL_PULSE;
            F3_RUN_MODE:     kind_s = CMD_RUN_MODE;
            default: begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end
          endcase
        end
        ST_CHIPID: begin
          chipid_s = shifted_s[3:0];
          echip_s  = shifted_s[3:0];
          if (kind_r == CMD_GLOBAL_RESET) begin
            emit_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_s  = shifted_s[5:0];
          eaddr_s = shifted_s[5:0];
          case (kind_r)
            CMD_RD_REG, CMD_GLOBAL_PULSE, CMD_RUN_MODE: begin
              emit_s  = 1'b1;
              state_s = ST_IDLE;
            end
            CMD_WR_REG: state_s = ST_DATA;
            CMD_WR_FE:  state_s = ST_FEDATA;
            default: begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end
          endcase
        end
        ST_DATA: begin
          emit_s   = 1'b1;
          evalue_s = shifted_s;
          state_s  = ST_IDLE;
        end
        ST_FEDATA: begin
          emit_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      cnt_s = cnt_inc_s;
      sh_s  = shifted_s[14:0];
    end
  end

  // State register, field registers and registered output record
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 10'd0;
      sh_r     <= 15'h0000;
      kind_r   <= CMD_NONE;
      chipid_r <= 4'h0;
      addr_r   <= 6'h00;
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
      type_r   <= CMD_NONE;
      ochip_r  <= 4'h0;
      oaddr_r  <= 6'h00;
      ovalue_r <= 16'h0000;
      trg_r    <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      sh_r     <= sh_s;
      kind_r   <= kind_s;
      chipid_r <= chipid_s;
      addr_r   <= addr_s;
      valid_r  <= emit_s;
      error_r  <= err_s;
      busy_r   <= (state_s != ST_IDLE);
      trg_r    <= trg_s;
      if (emit_s) begin
        type_r   <= etype_s;
        ochip_r  <= echip_s;
        oaddr_r  <= eaddr_s;
        ovalue_r <= evalue_s;
      end else begin
        type_r   <= type_r;
        ochip_r  <= ochip_r;
        oaddr_r  <= oaddr_r;
        ovalue_r <= ovalue_r;
      end
    end
  end

  assign CMD_VALID     = valid_r;
  assign CMD_ERROR     = error_r;
  assign CMD_TYPE      = type_r;
  assign CMD_CHIPID    = ochip_r;
  assign CMD_ADDR      = oaddr_r;
  assign CMD_VALUE     = ovalue_r;
  assign TRIGGER_COUNT = trg_r;
  assign RX_BUSY       = busy_r;

endmodule

// File: tb/tb_cmd_rx.sv
// tb_cmd_rx: directed scoreboard bench for cmd_rx.
// The stimulus process pushes the expected record (including the cycle it
// must appear in) when it drives the last bit of a command; a monitor pops
// and compares whenever CMD_VALID or CMD_ERROR is seen.
// The trigger counter is built 4 bits wide so its wrap is reachable quickly.
module tb_cmd_rx;

  localparam int TRG_W = 4;

  logic             clk;
  logic             BUS_RST;
  logic             CMD_DATA;
  logic             CMD_VALID;
  logic [3:0]       CMD_TYPE;
  logic [3:0]       CMD_CHIPID;
  logic [5:0]       CMD_ADDR;
  logic [15:0]      CMD_VALUE;
  logic             CMD_ERROR;
  logic [TRG_W-1:0] TRIGGER_COUNT;
  logic             RX_BUSY;

  typedef struct {
    bit          err;
    logic [3:0]  typ;
    logic [3:0]  chip;
    logic [5:0]  addr;
    logic [15:0] val;
    logic [TRG_W-1:0] trg;
    int          cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc_cnt = 0;
  logic [TRG_W-1:0] exp_trg = '0;

  cmd_rx #(.FE_DATA_BITS(672), .TRG_CNT_WIDTH(TRG_W)) dut (
    .BUS_CLK      (clk),
    .BUS_RST      (BUS_RST),
    .CMD_DATA     (CMD_DATA),
    .CMD_VALID    (CMD_VALID),
    .CMD_TYPE     (CMD_TYPE),
    .CMD_CHIPID   (CMD_CHIPID),
    .CMD_ADDR     (CMD_ADDR),
    .CMD_VALUE    (CMD_VALUE),
    .CMD_ERROR    (CMD_ERROR),
    .TRIGGER_COUNT(TRIGGER_COUNT),
    .RX_BUSY      (RX_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index of the most recent rising edge
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    CMD_DATA = b;
  endtask

  task automatic send_vec(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // Called right after the last bit is driven: it is sampled on the next edge
  task automatic push_ok(input logic [3:0] typ, input logic [3:0] chip,
                         input logic [5:0] addr, input logic [15:0] val);
    exp_t e;
    if (typ == 4'd1) exp_trg = exp_trg + 4'd1;
    e.err = 1'b0; e.typ = typ; e.chip = chip; e.addr = addr; e.val = val;
    e.trg = exp_trg; e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.typ = 4'd0; e.chip = 4'd0; e.addr = 6'd0; e.val = 16'd0;
    e.trg = exp_trg; e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, CMD_VALID}, 32'd0);
    chk({tag, "_error"}, {31'd0, CMD_ERROR}, 32'd0);
    chk({tag, "_type"},  {28'd0, CMD_TYPE}, 32'd0);
    chk({tag, "_chip"},  {28'd0, CMD_CHIPID}, 32'd0);
    chk({tag, "_addr"},  {26'd0, CMD_ADDR}, 32'd0);
    chk({tag, "_value"}, {16'd0, CMD_VALUE}, 32'd0);
    chk({tag, "_trg"},   {28'd0, TRIGGER_COUNT}, 32'd0);
    chk({tag, "_busy"},  {31'd0, RX_BUSY}, 32'd0);
  endtask

  // Monitor: compare every presented record against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (CMD_VALID && CMD_ERROR) begin
      checks++;
      errors++;
      $display("FAIL valid_and_error: both high at cycle %0d, required exclusive", cyc_cnt);
    end
    if (CMD_VALID || CMD_ERROR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: valid=%0b error=%0b type=%0d at cycle %0d, none expected",
                 CMD_VALID, CMD_ERROR, CMD_TYPE, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("rec_cycle", cyc_cnt, e.cyc);
        chk("rec_error", {31'd0, CMD_ERROR}, {31'd0, e.err});
        chk("rec_valid", {31'd0, CMD_VALID}, {31'd0, ~e.err});
        if (!e.err) begin
          chk("rec_type",  {28'd0, CMD_TYPE},      {28'd0, e.typ});
          chk("rec_chip",  {28'd0, CMD_CHIPID},    {28'd0, e.chip});
          chk("rec_addr",  {26'd0, CMD_ADDR},      {26'd0, e.addr});
          chk("rec_value", {16'd0, CMD_VALUE},     {16'd0, e.val});
          chk("rec_trg",   {28'd0, TRIGGER_COUNT}, {28'd0, e.trg});
        end
      end
    end
  end

  initial begin
    int busy_low;
    BUS_RST  = 1'b1;
    CMD_DATA = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    BUS_RST = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // LV1
    idle(2);
    send_vec(64'b11101, 5);
    push_ok(4'd1, 4'd0, 6'd0, 16'd0);
    send_bit(1'b0);
    chk("lv1_busy_mid_cmd_end", {31'd0, RX_BUSY}, 32'd0);
    idle(3);

    // BCR then ECR with zero gap
    send_vec(64'b10110_0001, 9);
    push_ok(4'd2, 4'd0, 6'd0, 16'd0);
    send_vec(64'b10110_0010, 9);
    push_ok(4'd3, 4'd0, 6'd0, 16'd0);
    idle(4);

    // WR_REG chip 8 addr 5 data 0xA5C3
    send_vec(64'b10110_1000_0010_1000_000101_1010010111000011, 39);
    push_ok(4'd6, 4'd8, 6'h05, 16'hA5C3);
    idle(4);

    // Bad header, then RD_REG chip 0 addr 0x2A
    send_vec(64'b10111, 5);
    push_err();
    idle(4);
    send_vec(64'b10110_1000_0001_0000_101010, 25);
    push_ok(4'd5, 4'd0, 6'h2A, 16'd0);
    idle(4);

    // GLOBAL_PULSE chip 0xF width 0x11, GLOBAL_RESET chip 0x6
    send_vec(64'b10110_1000_1001_1111_010001, 23);
    push_ok(4'd9, 4'hF, 6'h11, 16'd0);
    send_vec(64'b10110_1000_1000_0110, 17);
    push_ok(4'd8, 4'h6, 6'd0, 16'd0);
    idle(4);

    // WR_FE chip 3 addr 0 with 672 payload bits
    busy_low = 0;
    send_vec(64'b10110_1000_0100_0011_000000, 23);
    for (int i = 0; i < 672; i++) begin
      if (!RX_BUSY) busy_low++;
      send_bit(((i % 3) == 0) ? 1'b1 : 1'b0);
    end
    push_ok(4'd7, 4'h3, 6'd0, 16'd0);
    if (!RX_BUSY) busy_low++;
    send_bit(1'b0);
    chk("wrfe_busy_low_cycles", busy_low, 32'd0);
    chk("wrfe_busy_after", {31'd0, RX_BUSY}, 32'd0);
    idle(4);

    // Reset in the middle of WR_REG, after the address field
    send_vec(64'b10110_1000_0010_1000_000101, 23);
    send_bit(1'b1);
    BUS_RST = 1'b1;
    @(posedge clk);
    #1;
    BUS_RST  = 1'b0;
    CMD_DATA = 1'b0;
    exp_trg  = '0;
    @(negedge clk);
    chk_zero("midreset");
    idle(6);

    // Trigger counter wrap: 16 LV1 on a 4-bit counter ends at 0
    for (int i = 0; i < 16; i++) begin
      send_vec(64'b11101, 5);
      push_ok(4'd1, 4'd0, 6'd0, 16'd0);
    end
    idle(4);
    @(negedge clk);
    chk("trg_wrapped", {28'd0, TRIGGER_COUNT}, 32'd0);

    idle(10);
    chk("missing_records", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_rx.md
# cmd_rx

Serial command receiver and decoder for the FE-I4 command protocol: the receiving end of the command sequencer's bitstream. Samples one command bit per clock, frames and decodes trigger, fast and slow commands, and presents each decoded command as a registered one-cycle record. Used in the simulation/emulation path and for loop-back checking of the command sequencer output.

## Interface
- FE_DATA_BITS, 672: payload length of WrFrontEnd after the address field.
- TRG_CNT_WIDTH, 16: width of the trigger counter.

- BUS_CLK  input  1  the single clock; CMD_DATA is synchronous to it, one bit per cycle.
- BUS_RST  input  1  reset; synchronous and active-high.
- CMD_DATA  input  1  serial command bit, MSB first; idle line is 0.
- CMD_VALID  output  1  one-cycle pulse: record fields valid.
- CMD_TYPE  output  4  decoded type: 1 LV1, 2 BCR, 3 ECR, 4 CAL, 5 RD_REG, 6 WR_REG, 7 WR_FE, 8 GLOBAL_RESET, 9 GLOBAL_PULSE, 10 RUN_MODE.
- CMD_CHIPID  output  4  chip ID field (slow commands; 0 otherwise).
- CMD_ADDR  output  6  address / pulse width / run-mode field (0 if absent).
- CMD_VALUE  output  16  WR_REG data (0 otherwise).
- CMD_ERROR  output  1  one-cycle pulse on an unrecognised header or field.
- TRIGGER_COUNT  output  TRG_CNT_WIDTH  number of LV1 received, wraps.
- RX_BUSY  output  1  high while not in IDLE.

## Operation
- States: IDLE, HEADER, FIELD2, FIELD3, CHIPID, ADDR, DATA, FEDATA.
- IDLE: bit 1 is the first header bit -> HEADER (bit counter = 1); bit 0 stays IDLE.
- HEADER: after 5 bits total: 11101 -> emit LV1, IDLE; 10110 -> FIELD2; anything else -> CMD_ERROR, IDLE.
- FIELD2 (4 bits): 0001 BCR, 0010 ECR, 0100 CAL -> emit, IDLE; 1000 -> FIELD3; other -> CMD_ERROR, IDLE.
- FIELD3 (4 bits): 0001 RD_REG, 0010 WR_REG, 0100 WR_FE, 1000 GLOBAL_RESET, 1001 GLOBAL_PULSE, 1010 RUN_MODE -> CHIPID; other -> CMD_ERROR, IDLE.
- CHIPID (4 bits): GLOBAL_RESET emits after this field; all other types -> ADDR.
- ADDR (6 bits): RD_REG, GLOBAL_PULSE, RUN_MODE emit; WR_REG -> DATA; WR_FE -> FEDATA.
- DATA (16 bits, MSB first) -> emit WR_REG. FEDATA: count FE_DATA_BITS bits, data discarded -> emit WR_FE.
- Field shift registers are cleared on entry to HEADER; fields not carried by a type read 0.
- After an error the receiver resynchronises from IDLE; trailing bits of the bad command may decode further commands (accepted behaviour).
- TRIGGER_COUNT increments on every LV1 emission, wraps from all-ones to 0; not affected by ECR.

## Timing
- Latency: CMD_VALID (or CMD_ERROR) high in the cycle after the edge sampling the last bit of the command; record fields held until the next emission.
- Zero-gap back-to-back commands: the state returns to IDLE on the last-bit edge, so the next cycle's bit can be the next start bit.
- CMD_VALID and CMD_ERROR never assert together.
- Reset: all outputs 0, state IDLE, counters 0, on the first edge with BUS_RST high; a command in progress is dropped without VALID or ERROR.
- Bit counter 10 bits, sufficient for FE_DATA_BITS ≤ 1023.

## Structure
- Shared package: header codes (11101, 10110), field2/field3 codes, CMD_TYPE enumeration, field lengths (5, 4, 4, 4, 6, 16).
- Single module; no sub-module is natural (one shift register plus one counter).

## Test plan
- After reset, bits 11101 -> CMD_VALID one cycle later, CMD_TYPE 1, TRIGGER_COUNT 1; RX_BUSY low again.
- 10110 0001 then immediately 10110 0010 -> two VALID pulses 9 cycles apart, types 2 then 3.
- WR_REG chip 0x8 addr 0x05 data 0xA5C3 (10110 1000 0010 1000 000101 1010010111000011) -> VALID, type 6, CHIPID 8, ADDR 5, VALUE 0xA5C3.
- 10111 -> CMD_ERROR one cycle later, no VALID, then RD_REG chip 0 addr 0x2A decodes normally (type 5, ADDR 0x2A).
- WR_FE chip 0x3 addr 0 + 672 payload bits -> exactly one VALID, type 7, 1+4+4+4+4+6+672 bits after start; BUSY high throughout.
- BUS_RST mid-WR_REG (after ADDR) -> no VALID/ERROR, outputs 0; TRIGGER_COUNT wraps 0xFFFF -> 0 after 65536 LV1.
